// File: rtl/active_list_pkg.sv
// Shared definitions for the active list (in-flight instruction tracker).
// Used by dispatch and execute stages for tag width and entry layout.
package active_list_pkg;

    localparam int AL_DEPTH  = 16;
    localparam int AL_PREG_W = 6;
    localparam int AL_TAG_W  = $clog2(AL_DEPTH);

    // One in-flight instruction; dest is sized for the default register file.
    typedef struct packed {
        logic                 valid;
        logic                 done;
        logic                 writes_reg;
        logic [AL_PREG_W-1:0] dest;
        logic [31:0]          data;
    } active_list_entry_t;

endpackage

// File: rtl/active_list_commit_ifc.sv
// Commit write port from the active list to the register file.
interface active_List_Commit_ifc #(
    parameter int PREG_W = 6
);
    logic              Reg_WR_EN;
    logic [PREG_W-1:0] reg_addr;
    logic [31:0]       result_data;

    modport out (output Reg_WR_EN, output reg_addr, output result_data);
    modport in  (input  Reg_WR_EN, input  reg_addr, input  result_data);
endinterface

// File: rtl/active_list.sv
// Active list: circular buffer of in-flight instructions, dispatched in order,
// completed in any order, retired in order to the register file.
// Optional feature macro: ACTIVE_LIST_BYPASS_EN -- a completion hitting the
// valid, not-yet-done head slot retires in the same cycle.
// PREG_W must not exceed the package entry dest width.
module active_list
    import active_list_pkg::*;
#(
    parameter int DEPTH  = AL_DEPTH,
    parameter int PREG_W = AL_PREG_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     dispatch_valid,
    output logic                     dispatch_ready,
    input  logic                     dispatch_writes_reg,
    input  logic [PREG_W-1:0]        dispatch_dest,
    output logic [$clog2(DEPTH)-1:0] dispatch_tag,
    input  logic                     complete_valid,
    input  logic [$clog2(DEPTH)-1:0] complete_tag,
    input  logic [31:0]              complete_data,
    output logic                     commit_valid,
    active_List_Commit_ifc.out       o_commit,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full
);

    localparam int TAG_W = $clog2(DEPTH);
    localparam int PTR_W = TAG_W + 1;

    active_list_entry_t entries_q [DEPTH];
    active_list_entry_t entries_d [DEPTH];
    logic [PTR_W-1:0]   head_q, head_d;
    logic [PTR_W-1:0]   tail_q, tail_d;

    logic [TAG_W-1:0]   head_idx;
    logic [TAG_W-1:0]   tail_idx;
    active_list_entry_t head_e;
    logic               bypass;
    logic               commit;
    logic               dispatch_fire;
    logic               complete_hit;
    logic               wr_en;
    logic [31:0]        commit_data;

    assign head_idx = head_q[TAG_W-1:0];
    assign tail_idx = tail_q[TAG_W-1:0];
    assign head_e   = entries_q[head_idx];

    // Wrap bit makes the pointer difference distinguish full from empty.
    assign count          = tail_q - head_q;
    assign empty          = (count == {PTR_W{1'b0}});
    assign full           = (count == PTR_W'(DEPTH));
    assign dispatch_ready = !full;
    assign dispatch_tag   = tail_idx;

    // Head retirement decision and the value written back to the register file.
    always_comb begin
        bypass = 1'b0;
`ifdef ACTIVE_LIST_BYPASS_EN
        bypass = complete_valid && (complete_tag == head_idx) &&
                 head_e.valid && !head_e.done;
`endif
        // Reset and flush both suppress any retirement in their cycle.
        commit       = !rst && !flush && head_e.valid && (head_e.done || bypass);
        commit_data  = bypass ? complete_data : head_e.data;
        wr_en        = commit && head_e.writes_reg;
        complete_hit = complete_valid && entries_q[complete_tag].valid;
        // A slot freed by this cycle's commit is not reusable until next cycle.
        dispatch_fire = dispatch_valid && !full && !flush;
    end

    assign commit_valid         = commit;
    assign o_commit.Reg_WR_EN   = wr_en;
    assign o_commit.reg_addr    = wr_en ? PREG_W'(head_e.dest) : {PREG_W{1'b0}};
    assign o_commit.result_data = wr_en ? commit_data : 32'd0;

    // Next-state of slots and pointers; flush overrides every other update.
    always_comb begin
        entries_d = entries_q;
        head_d    = head_q;
        tail_d    = tail_q;
        if (flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries_d[i].valid = 1'b0;
            end
            tail_d = head_q;
        end else begin
            // Completion to an empty slot is dropped; a repeat overwrites data.
            if (complete_hit) begin
                entries_d[complete_tag].done = 1'b1;
                entries_d[complete_tag].data = complete_data;
            end else begin
                entries_d[complete_tag] = entries_d[complete_tag];
            end
            if (commit) begin
                entries_d[head_idx].valid = 1'b0;
                head_d = head_q + PTR_W'(1);
            end else begin
                head_d = head_q;
            end
            // Tail slot is never the committing slot: that needs a full list.
            if (dispatch_fire) begin
                entries_d[tail_idx].valid      = 1'b1;
                entries_d[tail_idx].done       = 1'b0;
                entries_d[tail_idx].writes_reg = dispatch_writes_reg;
                entries_d[tail_idx].dest       = AL_PREG_W'(dispatch_dest);
                entries_d[tail_idx].data       = 32'd0;
                tail_d = tail_q + PTR_W'(1);
            end else begin
                tail_d = tail_q;
            end
        end
    end

    // Slot storage and pointer registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q <= {PTR_W{1'b0}};
            tail_q <= {PTR_W{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                entries_q[i] <= '0;
            end
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            for (int i = 0; i < DEPTH; i++) begin
                entries_q[i] <= entries_d[i];
            end
        end
    end

endmodule

// File: tb/tb_active_list.sv
// Self-checking bench for active_list: directed table, hand sequences for
// full/flush/reset corners, and random traffic against a queue-based model.
module tb_active_list;
    import active_list_pkg::*;

    localparam int DEPTH  = 16;
    localparam int PREG_W = 6;
    localparam int TAG_W  = 4;

    logic              clk = 1'b0;
    logic              rst, flush;
    logic              dispatch_valid, dispatch_ready, dispatch_writes_reg;
    logic [PREG_W-1:0] dispatch_dest;
    logic [TAG_W-1:0]  dispatch_tag;
    logic              complete_valid;
    logic [TAG_W-1:0]  complete_tag;
    logic [31:0]       complete_data;
    logic              commit_valid;
    logic [TAG_W:0]    count;
    logic              empty, full;

    active_List_Commit_ifc #(.PREG_W(PREG_W)) commit_if ();

    active_list #(.DEPTH(DEPTH), .PREG_W(PREG_W)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .flush               (flush),
        .dispatch_valid      (dispatch_valid),
        .dispatch_ready      (dispatch_ready),
        .dispatch_writes_reg (dispatch_writes_reg),
        .dispatch_dest       (dispatch_dest),
        .dispatch_tag        (dispatch_tag),
        .complete_valid      (complete_valid),
        .complete_tag        (complete_tag),
        .complete_data       (complete_data),
        .commit_valid        (commit_valid),
        .o_commit            (commit_if),
        .count               (count),
        .empty               (empty),
        .full                (full)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: program-ordered queue of in-flight instructions.
    typedef struct {
        int          tag;
        bit          wr;
        int          dest;
        bit          done;
        logic [31:0] data;
    } ment_t;

    ment_t mq[$];
    int    mhead = 0;

    task automatic drive(input bit dv, input bit wr, input int dest, input bit cv,
                         input int ctag, input logic [31:0] cd, input bit fl, input bit r);
        dispatch_valid      = dv;
        dispatch_writes_reg = wr;
        dispatch_dest       = PREG_W'(dest);
        complete_valid      = cv;
        complete_tag        = TAG_W'(ctag);
        complete_data       = cd;
        flush               = fl;
        rst                 = r;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 0, 1'b0, 0, 32'd0, 1'b0, 1'b0);
    endtask

    // One clock: compare against the model before the edge, then advance it.
    task automatic step(input bit chk);
        int          cnt;
        bit          full_e, byp, cv_e, wr_e;
        int          new_tag;
        logic [31:0] data_e;
        int          addr_e;
        #1;
        cnt     = mq.size();
        full_e  = (cnt == DEPTH);
        new_tag = (mhead + cnt) % DEPTH;
        byp     = 1'b0;
`ifdef ACTIVE_LIST_BYPASS_EN
        if (cnt > 0) byp = complete_valid && (int'(complete_tag) == mhead) && !mq[0].done;
`endif
        cv_e   = !rst && !flush && (cnt > 0) && (mq[0].done || byp);
        wr_e   = cv_e && mq[0].wr;
        addr_e = wr_e ? mq[0].dest : 0;
        data_e = wr_e ? (byp ? complete_data : mq[0].data) : 32'd0;
        if (chk) begin
            check("count", 64'(count), 64'(cnt));
            check("empty", 64'(empty), 64'(cnt == 0));
            check("full", 64'(full), 64'(full_e));
            check("dispatch_ready", 64'(dispatch_ready), 64'(!full_e));
            check("dispatch_tag", 64'(dispatch_tag), 64'(new_tag));
            check("commit_valid", 64'(commit_valid), 64'(cv_e));
            check("Reg_WR_EN", 64'(commit_if.Reg_WR_EN), 64'(wr_e));
            check("reg_addr", 64'(commit_if.reg_addr), 64'(addr_e));
            check("result_data", 64'(commit_if.result_data), 64'(data_e));
        end
        @(posedge clk);
        if (rst) begin
            mq.delete();
            mhead = 0;
        end else if (flush) begin
            mq.delete();
        end else begin
            if (complete_valid) begin
                foreach (mq[i]) begin
                    if (mq[i].tag == int'(complete_tag)) begin
                        mq[i].done = 1'b1;
                        mq[i].data = complete_data;
                    end
                end
            end
            if (cv_e) begin
                void'(mq.pop_front());
                mhead = (mhead + 1) % DEPTH;
            end
            if (dispatch_valid && !full_e) begin
                mq.push_back('{new_tag, dispatch_writes_reg, int'(dispatch_dest), 1'b0, 32'd0});
            end
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        step(1'b1);
        idle();
    endtask

    typedef struct {
        bit          dv;
        bit          wr;
        int          dest;
        bit          cv;
        int          ctag;
        logic [31:0] cd;
        bit          ecv;
        bit          ewr;
        int          eaddr;
        logic [31:0] edata;
        int          ecount;
    } vec_t;

    function automatic vec_t mkv(bit dv, bit wr, int dest, bit cv, int ctag, logic [31:0] cd,
                                 bit ecv, bit ewr, int eaddr, logic [31:0] ed, int ecount);
        vec_t v;
        v = '{dv, wr, dest, cv, ctag, cd, ecv, ewr, eaddr, ed, ecount};
        return v;
    endfunction

    vec_t tbl[$];

    initial begin
        // Directed table: in-order retirement of out-of-order completions,
        // then a no-destination instruction.
        tbl.push_back(mkv(1, 1, 5, 0, 0, 32'h0,  0, 0, 0, 32'h0,  0));
        tbl.push_back(mkv(1, 1, 6, 0, 0, 32'h0,  0, 0, 0, 32'h0,  1));
        tbl.push_back(mkv(1, 1, 7, 0, 0, 32'h0,  0, 0, 0, 32'h0,  2));
        tbl.push_back(mkv(0, 0, 0, 1, 2, 32'h22, 0, 0, 0, 32'h0,  3));
        tbl.push_back(mkv(0, 0, 0, 1, 1, 32'h11, 0, 0, 0, 32'h0,  3));
`ifdef ACTIVE_LIST_BYPASS_EN
        tbl.push_back(mkv(0, 0, 0, 1, 0, 32'h00, 1, 1, 5, 32'h00, 3));
        tbl.push_back(mkv(0, 0, 0, 0, 0, 32'h0,  1, 1, 6, 32'h11, 2));
        tbl.push_back(mkv(0, 0, 0, 0, 0, 32'h0,  1, 1, 7, 32'h22, 1));
        tbl.push_back(mkv(0, 0, 0, 0, 0, 32'h0,  0, 0, 0, 32'h0,  0));
        tbl.push_back(mkv(1, 0, 9, 0, 0, 32'h0,  0, 0, 0, 32'h0,  0));
        tbl.push_back(mkv(0, 0, 0, 1, 3, 32'hDEADBEEF, 1, 0, 0, 32'h0, 1));
        tbl.push_back(mkv(0, 0, 0, 0, 0, 32'h0,  0, 0, 0, 32'h0,  0));
`else
        tbl.push_back(mkv(0, 0, 0, 1, 0, 32'h00, 0, 0, 0, 32'h0,  3));
        tbl.push_back(mkv(0, 0, 0, 0, 0, 32'h0,  1, 1, 5, 32'h00, 3));
        tbl.push_back(mkv(0, 0, 0, 0, 0, 32'h0,  1, 1, 6, 32'h11, 2));
        tbl.push_back(mkv(0, 0, 0, 0, 0, 32'h0,  1, 1, 7, 32'h22, 1));
        tbl.push_back(mkv(0, 0, 0, 0, 0, 32'h0,  0, 0, 0, 32'h0,  0));
        tbl.push_back(mkv(1, 0, 9, 0, 0, 32'h0,  0, 0, 0, 32'h0,  0));
        tbl.push_back(mkv(0, 0, 0, 1, 3, 32'hDEADBEEF, 0, 0, 0, 32'h0, 1));
        tbl.push_back(mkv(0, 0, 0, 0, 0, 32'h0,  1, 0, 0, 32'h0,  1));
        tbl.push_back(mkv(0, 0, 0, 0, 0, 32'h0,  0, 0, 0, 32'h0,  0));
`endif

        // Power-up reset: state unknown before the first edge, so no compare.
        idle();
        rst = 1'b1;
        @(negedge clk);
        step(1'b0);
        idle();

        // Reset state.
        #1;
        check("reset empty", 64'(empty), 64'd1);
        check("reset full", 64'(full), 64'd0);
        check("reset dispatch_ready", 64'(dispatch_ready), 64'd1);
        check("reset commit_valid", 64'(commit_valid), 64'd0);
        check("reset Reg_WR_EN", 64'(commit_if.Reg_WR_EN), 64'd0);
        check("reset reg_addr", 64'(commit_if.reg_addr), 64'd0);
        check("reset result_data", 64'(commit_if.result_data), 64'd0);
        check("reset count", 64'(count), 64'd0);
        step(1'b1);

        // Table-driven vectors.
        foreach (tbl[i]) begin
            drive(tbl[i].dv, tbl[i].wr, tbl[i].dest, tbl[i].cv, tbl[i].ctag, tbl[i].cd, 1'b0, 1'b0);
            #1;
            check($sformatf("tbl[%0d] commit_valid", i), 64'(commit_valid), 64'(tbl[i].ecv));
            check($sformatf("tbl[%0d] Reg_WR_EN", i), 64'(commit_if.Reg_WR_EN), 64'(tbl[i].ewr));
            check($sformatf("tbl[%0d] reg_addr", i), 64'(commit_if.reg_addr), 64'(tbl[i].eaddr));
            check($sformatf("tbl[%0d] result_data", i), 64'(commit_if.result_data), 64'(tbl[i].edata));
            check($sformatf("tbl[%0d] count", i), 64'(count), 64'(tbl[i].ecount));
            step(1'b1);
        end

        // Fill to capacity, then free the head while offering a dispatch.
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b1, 1'b1, i, 1'b0, 0, 32'd0, 1'b0, 1'b0);
            step(1'b1);
        end
        idle();
        #1;
        check("fill full", 64'(full), 64'd1);
        check("fill dispatch_ready", 64'(dispatch_ready), 64'd0);
        check("fill count", 64'(count), 64'd16);
        step(1'b1);
        drive(1'b1, 1'b1, 40, 1'b1, 0, 32'hA0, 1'b0, 1'b0);
        #1;
        check("fill cycleA dispatch_ready", 64'(dispatch_ready), 64'd0);
`ifdef ACTIVE_LIST_BYPASS_EN
        check("fill cycleA commit_valid", 64'(commit_valid), 64'd1);
`else
        check("fill cycleA commit_valid", 64'(commit_valid), 64'd0);
        step(1'b1);
        drive(1'b1, 1'b1, 40, 1'b0, 0, 32'd0, 1'b0, 1'b0);
        #1;
        check("fill cycleB commit_valid", 64'(commit_valid), 64'd1);
        check("fill cycleB dispatch_ready", 64'(dispatch_ready), 64'd0);
`endif
        step(1'b1);
        drive(1'b1, 1'b1, 41, 1'b0, 0, 32'd0, 1'b0, 1'b0);
        #1;
        check("wrap dispatch_ready", 64'(dispatch_ready), 64'd1);
        check("wrap dispatch_tag", 64'(dispatch_tag), 64'd0);
        step(1'b1);
        idle();
        #1;
        check("wrap count", 64'(count), 64'd16);
        step(1'b1);

        // Flush colliding with a head completion and a dispatch.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b1, 10 + i, 1'b0, 0, 32'd0, 1'b0, 1'b0);
            step(1'b1);
        end
        drive(1'b1, 1'b1, 20, 1'b1, 0, 32'h55, 1'b1, 1'b0);
        #1;
        check("flush commit_valid", 64'(commit_valid), 64'd0);
        check("flush Reg_WR_EN", 64'(commit_if.Reg_WR_EN), 64'd0);
        step(1'b1);
        idle();
        #1;
        check("post-flush count", 64'(count), 64'd0);
        check("post-flush empty", 64'(empty), 64'd1);
        check("post-flush dispatch_tag", 64'(dispatch_tag), 64'd0);
        step(1'b1);

        // Reset mid-stream with a completed entry at the head.
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1, 30 + i, 1'b0, 0, 32'd0, 1'b0, 1'b0);
            step(1'b1);
        end
        drive(1'b0, 1'b0, 0, 1'b1, 1, 32'h77, 1'b0, 1'b0);
        step(1'b1);
        drive(1'b0, 1'b0, 0, 1'b1, 0, 32'h66, 1'b0, 1'b0);
        step(1'b1);
        drive(1'b1, 1'b1, 33, 1'b0, 0, 32'd0, 1'b0, 1'b1);
        #1;
        check("rst-mid Reg_WR_EN", 64'(commit_if.Reg_WR_EN), 64'd0);
        check("rst-mid commit_valid", 64'(commit_valid), 64'd0);
        step(1'b1);
        idle();
        #1;
        check("post-rst count", 64'(count), 64'd0);
        check("post-rst empty", 64'(empty), 64'd1);
        check("post-rst full", 64'(full), 64'd0);
        check("post-rst dispatch_ready", 64'(dispatch_ready), 64'd1);
        check("post-rst reg_addr", 64'(commit_if.reg_addr), 64'd0);
        check("post-rst result_data", 64'(commit_if.result_data), 64'd0);
        step(1'b1);

        // Random traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            int ctag;
            if (mq.size() > 0 && $urandom_range(3) != 0)
                ctag = mq[$urandom_range(mq.size() - 1)].tag;
            else
                ctag = int'($urandom_range(DEPTH - 1));
            drive($urandom_range(9) < 7, 1'($urandom), int'($urandom_range(63)),
                  1'($urandom), ctag, $urandom,
                  $urandom_range(99) < 2, $urandom_range(199) == 0);
            step(1'b1);
        end

        idle();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/active_list.md
ACTIVE_LIST -- requirements
Module: active_list

Interface
REQ-001 The block SHALL have parameter DEPTH, default 16, number of in-flight entries (power of two, >=2).
REQ-002 The block SHALL have parameter PREG_W, default 6, physical register address width (64 regs).
REQ-003 The block SHALL have ports as follows, one per line (name direction width meaning):
 clk  input  1  sole clock, rising edge
 rst  input  1  synchronous, active-high reset
 flush  input  1  discard all in-flight entries
 dispatch_valid  input  1  new instruction offered in program order
 dispatch_ready  output  1  entry available
 dispatch_writes_reg  input  1  instruction has a register destination
 dispatch_dest  input  PREG_W  destination physical register
 dispatch_tag  output  log2(DEPTH)  slot index assigned to the offered instruction
 complete_valid  input  1  execution result returning, any order
 complete_tag  input  log2(DEPTH)  slot being completed
 complete_data  input  32  result value
 commit_valid  output  1  head entry retires this cycle
 o_commit  active_List_Commit_ifc.out  -  Reg_WR_EN, reg_addr (PREG_W), result_data (32) to register file
 count  output  log2(DEPTH)+1  occupied entries
 empty, full  output  1 each  occupancy flags
REQ-004 Clock and reset SHALL be one clock and synchronous active-high reset, named clk and rst.

Function
REQ-005 Entries SHALL be a circular buffer with head/tail pointers of log2(DEPTH)+1 bits; the extra wrap bit distinguishes full from empty.
REQ-006 dispatch_ready SHALL equal !full; dispatch_tag SHALL equal tail index combinationally.
REQ-007 On dispatch_valid && dispatch_ready, the tail slot SHALL become valid, not done, storing writes_reg and dest, and tail SHALL advance by one, wrapping DEPTH-1 -> 0.
REQ-008 On complete_valid to a valid slot, that slot SHALL become done and store complete_data; completion to an invalid slot SHALL be ignored; completion to an already done slot SHALL overwrite data.
REQ-009 commit_valid SHALL be high when the head slot is valid and done and flush is low; on that edge the head slot SHALL become invalid and head SHALL advance.
REQ-010 o_commit.Reg_WR_EN SHALL equal commit_valid && head writes_reg; reg_addr and result_data SHALL carry head dest/data when Reg_WR_EN is high and SHALL be 0 otherwise.
REQ-011 At most one commit and one dispatch SHALL occur per cycle; both may occur in the same cycle; a slot freed by commit SHALL NOT be dispatchable until the next cycle (full stays full that cycle).
REQ-012 count SHALL be tail - head (wrap-aware); empty = (count==0); full = (count==DEPTH).
REQ-013 flush SHALL take priority over dispatch, completion and commit: all slots invalid, tail set to head, count 0, no register write that cycle.

Reset
REQ-014 When rst is high at a clock edge, head=tail=0, all slots invalid, count=0; the following cycle empty=1, full=0, dispatch_ready=1, commit_valid=0, Reg_WR_EN=0, reg_addr=0, result_data=0.
REQ-015 Reset mid-operation SHALL discard all entries with no register write in the reset cycle.

Configuration
REQ-016 Macro ACTIVE_LIST_BYPASS_EN: when defined, a completion targeting the valid, not-done head slot SHALL commit in the same cycle using complete_data (zero extra latency); when undefined, that entry SHALL commit in the cycle after completion (one cycle latency).

Structure
REQ-017 DEPTH default, tag width and typedef active_list_entry_t (valid, done, writes_reg, dest, data) SHALL live in a shared package used by dispatch and execute stages.
REQ-018 No sub-module is required; storage and pointers SHALL be in active_list.

Verification
REQ-019 Reset, dispatch 3 entries (dest 5,6,7), complete tags 2,1,0 with 0x22,0x11,0x00 -> commits in order to regs 5,6,7 with 0x00,0x11,0x22 on consecutive cycles.
REQ-020 Dispatch 16 entries -> full=1, dispatch_ready=0, count=16; complete head and commit while offering dispatch -> dispatch accepted only the next cycle, tag wraps to 0.
REQ-021 Entry with dispatch_writes_reg=0 completed -> commit_valid=1, Reg_WR_EN=0, reg_addr=0, result_data=0.
REQ-022 Complete head at cycle N -> commit at cycle N with ACTIVE_LIST_BYPASS_EN, at N+1 without.
REQ-023 5 entries, flush asserted same cycle as head completion and a dispatch -> no write, count=0, empty=1 next cycle; rst asserted mid-stream -> identical empty state.
